// File: rtl/ex_stage_reg.sv
// EX stage: unpacks the ID/EX bus, runs the ALU, iterative multiply and branch target, registers EX/MEM.
// Latency: 1 edge for ALU ops; a multiply holds for 1 + 32/MUL_BPC cycles, then commits on the following edge.
// Backpressure: ex_busy asks ID/EX to hold while a multiply is in progress; flush and rst abort it.
module ex_stage_reg #(
   parameter int MUL_BPC = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic [146:0] idex_in,
   output logic         ex_busy,
   output logic [106:0] exmem_out
);

   localparam int MUL_ITERS = 32 / MUL_BPC;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // ID/EX fields
   logic [1:0]  wb_f;
   logic [2:0]  m_f;
   logic        reg_dst;
   logic [1:0]  alu_op;
   logic        alu_src;
   logic [31:0] add4_f;
   logic [31:0] rd1_f;
   logic [31:0] rd2_f;
   logic [31:0] sext_f;
   logic [4:0]  rt_f;
   logic [4:0]  rd_f;
   logic [5:0]  funct;
   logic [4:0]  shamt;

   assign wb_f    = idex_in[146:145];
   assign m_f     = idex_in[144:142];
   assign reg_dst = idex_in[141];
   assign alu_op  = idex_in[140:139];
   assign alu_src = idex_in[138];
   assign add4_f  = idex_in[137:106];
   assign rd1_f   = idex_in[105:74];
   assign rd2_f   = idex_in[73:42];
   assign sext_f  = idex_in[41:10];
   assign rt_f    = idex_in[9:5];
   assign rd_f    = idex_in[4:0];
   assign funct   = sext_f[5:0];
   assign shamt   = sext_f[10:6];

   logic [31:0] op_b;
   logic [4:0]  dest;
   logic [31:0] btgt;
   logic [31:0] alu_res;
   logic        is_mul;

   assign op_b   = alu_src ? sext_f : rd2_f;
   assign dest   = reg_dst ? rd_f : rt_f;
   assign btgt   = add4_f + {sext_f[29:0], 2'b00};
   assign is_mul = (alu_op == 2'b10) && (funct == 6'h18);

   // Single-cycle ALU; multiply results come from the iterative unit instead
   always_comb begin
      alu_res = 32'h0;
      case (alu_op)
         2'b00:   alu_res = rd1_f + op_b;
         2'b01:   alu_res = rd1_f - op_b;
         2'b11:   alu_res = rd1_f | {16'h0, sext_f[15:0]};
         default: begin
            case (funct)
               6'h20:   alu_res = rd1_f + op_b;
               6'h22:   alu_res = rd1_f - op_b;
               6'h24:   alu_res = rd1_f & op_b;
               6'h25:   alu_res = rd1_f | op_b;
               6'h2A:   alu_res = {31'h0, $signed(rd1_f) < $signed(op_b)};
               6'h00:   alu_res = op_b << shamt;
               default: alu_res = 32'h0;
            endcase
         end
      endcase
   end

   // Multiplier and pipeline state
   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [106:0] exmem_q, exmem_d;
   logic        busy_c;
   logic [31:0] partial;

   // Low MUL_BPC multiplier bits times the shifted multiplicand, truncated to 32 bits
   assign partial = mcand_q * {{(32 - MUL_BPC){1'b0}}, mplier_q[MUL_BPC-1:0]};

   // Next-state, multiplier step and EX/MEM bundle selection; flush overrides everything
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      busy_c   = 1'b0;
      exmem_d  = {wb_f, m_f, btgt, (alu_res == 32'h0), alu_res, rd2_f, dest};
      case (state_q)
         S_IDLE: begin
            if (is_mul) begin
               busy_c   = 1'b1;
               exmem_d  = '0;
               mcand_d  = rd1_f;
               mplier_d = rd2_f;
               acc_d    = 32'h0;
               cnt_d    = 6'd0;
               state_d  = S_MUL;
            end
         end
         S_MUL: begin
            busy_c   = 1'b1;
            exmem_d  = '0;
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << MUL_BPC;
            mplier_d = mplier_q >> MUL_BPC;
            cnt_d    = cnt_q + 6'd1;
            if (cnt_q == 6'(MUL_ITERS - 1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            exmem_d = {wb_f, m_f, btgt, (acc_q == 32'h0), acc_q, rd2_f, dest};
            state_d = S_IDLE;
         end
         default: begin
            exmem_d = '0;
            state_d = S_IDLE;
         end
      endcase
      if (flush) begin
         state_d = S_IDLE;
         exmem_d = '0;
         cnt_d   = 6'd0;
         acc_d   = 32'h0;
      end
   end

   // State registers; rst takes priority over flush
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 6'd0;
         acc_q    <= 32'h0;
         mcand_q  <= 32'h0;
         mplier_q <= 32'h0;
         exmem_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         exmem_q  <= exmem_d;
      end
   end

   assign ex_busy   = busy_c & ~rst & ~flush;
   assign exmem_out = exmem_q;

endmodule

// File: tb/tb_ex_stage_reg.sv
// Scoreboard bench for ex_stage_reg: two instances (MUL_BPC=1 and 4) share the stimulus.
// Latency: expected EX/MEM value is queued at drive time and compared one edge later.
// Backpressure: ex_busy is checked every driven cycle against the expected hold pattern.
module tb_ex_stage_reg;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         flush = 1'b0;
   logic [146:0] idex_in = '0;
   logic         busy1, busy4;
   logic [106:0] exm1, exm4;
   int           sel = 1;

   logic [106:0] exp_q[$];
   int           n_chk = 0;
   int           n_pass = 0;

   always #5 clk = ~clk;

   ex_stage_reg #(.MUL_BPC(1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .idex_in(idex_in),
      .ex_busy(busy1), .exmem_out(exm1)
   );

   ex_stage_reg #(.MUL_BPC(4)) dut4 (
      .clk(clk), .rst(rst), .flush(flush), .idex_in(idex_in),
      .ex_busy(busy4), .exmem_out(exm4)
   );

   task automatic check(input string tag, input logic [106:0] got, input logic [106:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [146:0] mk(input logic [1:0] wb, input logic [2:0] m,
                                       input logic [3:0] ex, input logic [31:0] add4,
                                       input logic [31:0] rd1, input logic [31:0] rd2,
                                       input logic [31:0] sext, input logic [4:0] rt,
                                       input logic [4:0] rd);
      return {wb, m, ex, add4, rd1, rd2, sext, rt, rd};
   endfunction

   // Reference: what EX/MEM should hold once this instruction commits
   function automatic logic [106:0] model(input logic [146:0] ins);
      logic [31:0] add4, rd1, rd2, sext, ob, alu;
      logic [63:0] prod;
      logic [5:0]  fn;
      add4 = ins[137:106];
      rd1  = ins[105:74];
      rd2  = ins[73:42];
      sext = ins[41:10];
      fn   = sext[5:0];
      ob   = ins[138] ? sext : rd2;
      prod = {32'h0, rd1} * {32'h0, rd2};
      alu  = 32'h0;
      if (ins[140:139] == 2'b00) alu = rd1 + ob;
      else if (ins[140:139] == 2'b01) alu = rd1 - ob;
      else if (ins[140:139] == 2'b11) alu = rd1 | (sext & 32'h0000FFFF);
      else if (fn == 6'h20) alu = rd1 + ob;
      else if (fn == 6'h22) alu = rd1 - ob;
      else if (fn == 6'h24) alu = rd1 & ob;
      else if (fn == 6'h25) alu = rd1 | ob;
      else if (fn == 6'h2A) alu = ($signed(rd1) < $signed(ob)) ? 32'd1 : 32'd0;
      else if (fn == 6'h00) alu = ob << sext[10:6];
      else if (fn == 6'h18) alu = prod[31:0];
      return {ins[146:145], ins[144:142], add4 + (sext * 32'd4), (alu == 32'h0), alu, rd2,
              ins[141] ? ins[4:0] : ins[9:5]};
   endfunction

   task automatic step(input string tag, input logic [146:0] ins, input logic fl,
                       input logic rs, input logic chk_busy, input logic exp_busy,
                       input logic [106:0] exp_out);
      logic b;
      @(negedge clk);
      idex_in = ins;
      flush   = fl;
      rst     = rs;
      #1;
      b = (sel == 4) ? busy4 : busy1;
      if (chk_busy) check({tag, ".busy"}, {106'h0, b}, {106'h0, exp_busy});
      exp_q.push_back(exp_out);
      @(posedge clk);
      #1;
      check(tag, (sel == 4) ? exm4 : exm1, exp_q.pop_front());
   endtask

   task automatic alu_is(input string tag, input logic [31:0] exp);
      logic [106:0] o;
      o = (sel == 4) ? exm4 : exm1;
      check({tag, ".alu"}, {75'h0, o[68:37]}, {75'h0, exp});
   endtask

   task automatic run_mul(input string tag, input logic [146:0] ins, input int busy_cycles);
      for (int i = 0; i < busy_cycles; i++) step(tag, ins, 1'b0, 1'b0, 1'b1, 1'b1, '0);
      step({tag, ".done"}, ins, 1'b0, 1'b0, 1'b1, 1'b0, model(ins));
   endtask

   task automatic bubbles(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, '0, 1'b0, 1'b0, 1'b1, 1'b0, model('0));
   endtask

   logic [146:0] ins;
   logic [146:0] mul_i;
   logic [106:0] o;

   initial begin
      mul_i = mk(2'b10, 3'b000, 4'hC, 32'h200, 32'h10000, 32'h10003, 32'h18, 5'd1, 5'd2);

      // Reset, including with a live instruction on the bus
      step("rst0", '0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
      step("rst1", '0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
      ins = mk(2'b11, 3'b101, 4'hC, 32'h4, 32'd5, 32'd7, 32'h20, 5'd9, 5'd3);
      step("rst_nz", ins, 1'b0, 1'b1, 1'b1, 1'b0, '0);

      // ALU ops
      step("add", ins, 1'b0, 1'b0, 1'b1, 1'b0, model(ins));
      alu_is("add", 32'd12);
      o = exm1;
      check("add.dest", {102'h0, o[4:0]}, {102'h0, 5'd3});
      check("add.zero", {106'h0, o[69]}, 107'h0);

      ins = mk(2'b01, 3'b000, 4'hC, 32'h8, 32'd7, 32'd7, 32'h22, 5'd4, 5'd6);
      step("sub", ins, 1'b0, 1'b0, 1'b1, 1'b0, model(ins));
      o = exm1;
      check("sub.zero", {106'h0, o[69]}, {106'h0, 1'b1});

      ins = mk(2'b10, 3'b000, 4'hC, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd1, 5'd2);
      step("slt", ins, 1'b0, 1'b0, 1'b1, 1'b0, model(ins));
      alu_is("slt", 32'd1);

      ins = mk(2'b10, 3'b000, 4'hC, 32'h0, 32'h0, 32'd1, 32'h7C0, 5'd1, 5'd2);
      step("sll", ins, 1'b0, 1'b0, 1'b1, 1'b0, model(ins));
      alu_is("sll", 32'h80000000);

      ins = mk(2'b10, 3'b000, 4'hC, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h20, 5'd1, 5'd2);
      step("addwrap", ins, 1'b0, 1'b0, 1'b1, 1'b0, model(ins));
      alu_is("addwrap", 32'h0);

      ins = mk(2'b00, 3'b100, 4'h2, 32'h100, 32'd9, 32'd9, 32'hFFFFFFFF, 5'd1, 5'd2);
      step("beq", ins, 1'b0, 1'b0, 1'b1, 1'b0, model(ins));
      o = exm1;
      check("beq.btgt", {75'h0, o[101:70]}, {75'h0, 32'h000000FC});

      ins = mk(2'b10, 3'b000, 4'h1, 32'h0, 32'd4, 32'd99, 32'hFFFFFFFC, 5'd7, 5'd2);
      step("addi", ins, 1'b0, 1'b0, 1'b1, 1'b0, model(ins));
      alu_is("addi", 32'h0);

      ins = mk(2'b10, 3'b000, 4'h7, 32'h0, 32'h12340000, 32'd0, 32'hFFFF8001, 5'd7, 5'd2);
      step("ori", ins, 1'b0, 1'b0, 1'b1, 1'b0, model(ins));
      alu_is("ori", 32'h12348001);

      ins = mk(2'b10, 3'b010, 4'hC, 32'h0, 32'hF0F0A5A5, 32'h0FF0FF00, 32'h24, 5'd1, 5'd8);
      step("and", ins, 1'b0, 1'b0, 1'b1, 1'b0, model(ins));
      ins = mk(2'b10, 3'b010, 4'hC, 32'h0, 32'hF0F0A5A5, 32'h0FF0FF00, 32'h25, 5'd1, 5'd8);
      step("or", ins, 1'b0, 1'b0, 1'b1, 1'b0, model(ins));
      ins = mk(2'b10, 3'b010, 4'hC, 32'h0, 32'hF0F0A5A5, 32'h0FF0FF00, 32'h3F, 5'd1, 5'd8);
      step("badfn", ins, 1'b0, 1'b0, 1'b1, 1'b0, model(ins));
      alu_is("badfn", 32'h0);
      bubbles("bubble", 2);

      // Multiply, one bit per cycle; the following instruction must run normally
      run_mul("mul1", mul_i, 33);
      alu_is("mul1", 32'h00030000);
      ins = mk(2'b11, 3'b101, 4'hC, 32'h4, 32'd5, 32'd7, 32'h20, 5'd9, 5'd3);
      step("post_mul", ins, 1'b0, 1'b0, 1'b1, 1'b0, model(ins));
      bubbles("bubble", 2);

      // Multiply, four bits per cycle
      sel = 4;
      step("rst4", '0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
      run_mul("mul4", mul_i, 9);
      alu_is("mul4", 32'h00030000);
      bubbles("bubble4", 2);

      // Flush in MUL cycle 10, then rst in cycle 5 of a second multiply
      sel = 1;
      step("rst5", '0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
      for (int i = 0; i < 11; i++) step("mulf", mul_i, 1'b0, 1'b0, 1'b1, 1'b1, '0);
      step("flush", '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      bubbles("post_flush", 40);
      for (int i = 0; i < 6; i++) step("mulr", mul_i, 1'b0, 1'b0, 1'b1, 1'b1, '0);
      step("rst_mid", '0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
      bubbles("post_rst", 40);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
